// File: rtl/eth_mdio_master.sv
// Clause-22 MDIO management master: serialises one read/write frame per request.
// Optional macro ETH_MDIO_PREAMBLE_SUPPRESS_EN drops the 32-bit preamble.
module eth_mdio_master #(
    parameter int CLK_DIV = 20
) (
    input  logic        msoc_clk,
    input  logic        rst_int,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic [4:0]  req_phy,
    input  logic [4:0]  req_reg,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        phy_mdc,
    output logic        phy_mdio_o,
    output logic        phy_mdio_oe,
    input  logic        phy_mdio_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_END
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic        mdc_q, mdc_d;
    logic [5:0]  bit_q, bit_d;
    logic        rd_q, rd_d;
    logic [4:0]  phy_q, phy_d;
    logic [4:0]  reg_q, reg_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] shift_q, shift_d;
    logic        ta_err_q, ta_err_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        div_last, bit_end, sample;
    logic [13:0] hdr;

    assign div_last = (div_q == DIV_LAST);
    assign bit_end  = mdc_q & div_last;
    // MDI is taken on the first cycle of the high phase, i.e. right at the MDC rise
    assign sample   = mdc_q & (div_q == 8'd0);
    assign hdr      = {2'b01, (rd_q ? 2'b10 : 2'b01), phy_q, reg_q};

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        mdc_d    = mdc_q;
        bit_d    = bit_q;
        rd_d     = rd_q;
        phy_d    = phy_q;
        reg_d    = reg_q;
        wdata_d  = wdata_q;
        shift_d  = shift_q;
        ta_err_d = ta_err_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    rd_d     = req_read;
                    phy_d    = req_phy;
                    reg_d    = req_reg;
                    wdata_d  = req_wdata;
                    ta_err_d = 1'b0;
                    div_d    = 8'd0;
                    mdc_d    = 1'b0;
`ifdef ETH_MDIO_PREAMBLE_SUPPRESS_EN
                    state_d  = S_HDR;
                    bit_d    = 6'd13;
`else
                    state_d  = S_PRE;
                    bit_d    = 6'd31;
`endif
                end
            end
            S_PRE, S_HDR, S_TA, S_DATA: begin
                if (div_last) begin
                    div_d = 8'd0;
                    mdc_d = ~mdc_q;
                end else begin
                    div_d = div_q + 8'd1;
                end

                if (sample && rd_q) begin
                    if (state_q == S_TA && bit_q == 6'd0 && phy_mdio_i)
                        ta_err_d = 1'b1;
                    if (state_q == S_DATA)
                        shift_d = {shift_q[14:0], phy_mdio_i};
                end

                if (bit_end) begin
                    if (bit_q != 6'd0) begin
                        bit_d = bit_q - 6'd1;
                    end else begin
                        case (state_q)
                            S_PRE: begin
                                state_d = S_HDR;
                                bit_d   = 6'd13;
                            end
                            S_HDR: begin
                                state_d = S_TA;
                                bit_d   = 6'd1;
                            end
                            S_TA: begin
                                state_d = S_DATA;
                                bit_d   = 6'd15;
                            end
                            default: begin
                                // response fields are visible during the END cycle
                                state_d = S_END;
                                bit_d   = 6'd0;
                                err_d   = rd_q & ta_err_q;
                                if (rd_q)
                                    rdata_d = shift_q;
                            end
                        endcase
                    end
                end
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge msoc_clk) begin
        if (rst_int) begin
            state_q  <= S_IDLE;
            div_q    <= 8'd0;
            mdc_q    <= 1'b0;
            bit_q    <= 6'd0;
            rd_q     <= 1'b0;
            phy_q    <= 5'd0;
            reg_q    <= 5'd0;
            wdata_q  <= 16'd0;
            shift_q  <= 16'd0;
            ta_err_q <= 1'b0;
            rdata_q  <= 16'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            mdc_q    <= mdc_d;
            bit_q    <= bit_d;
            rd_q     <= rd_d;
            phy_q    <= phy_d;
            reg_q    <= reg_d;
            wdata_q  <= wdata_d;
            shift_q  <= shift_d;
            ta_err_q <= ta_err_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Drive values depend only on state and bit index, so they move only at bit starts
    always_comb begin
        phy_mdio_o  = 1'b1;
        phy_mdio_oe = 1'b0;
        case (state_q)
            S_PRE: begin
                phy_mdio_oe = 1'b1;
            end
            S_HDR: begin
                phy_mdio_o  = hdr[bit_q[3:0]];
                phy_mdio_oe = 1'b1;
            end
            S_TA: begin
                if (!rd_q) begin
                    phy_mdio_o  = bit_q[0];
                    phy_mdio_oe = 1'b1;
                end
            end
            S_DATA: begin
                if (!rd_q) begin
                    phy_mdio_o  = wdata_q[bit_q[3:0]];
                    phy_mdio_oe = 1'b1;
                end
            end
            default: begin
                phy_mdio_o  = 1'b1;
                phy_mdio_oe = 1'b0;
            end
        endcase
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = ~req_ready;
    assign rsp_valid = (state_q == S_END);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign phy_mdc   = mdc_q;

endmodule

// File: tb/tb_eth_mdio_master.sv
// Scoreboard bench for eth_mdio_master: directed frames, PHY model, MDC-edge frame capture.
module tb_eth_mdio_master;
`ifdef ETH_MDIO_PREAMBLE_SUPPRESS_EN
    localparam int CLK_DIV = 2;
    localparam int N       = 32;
`else
    localparam int CLK_DIV = 4;
    localparam int N       = 64;
`endif
    localparam int PRE = N - 32;
    localparam int LAT = 1 + 2 * CLK_DIV * N;
    localparam logic [63:0] MASK_N  = (N == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] MASK_RD = MASK_N & ~64'h0000_0000_0003_FFFF;

    logic        clk = 1'b0;
    logic        rst_int;
    logic        req_valid, req_ready, req_read;
    logic [4:0]  req_phy, req_reg;
    logic [15:0] req_wdata;
    logic        rsp_valid, rsp_err, busy;
    logic [15:0] rsp_rdata;
    logic        phy_mdc, phy_mdio_o, phy_mdio_oe;
    logic        phy_mdio_i = 1'b1;

    eth_mdio_master #(.CLK_DIV(CLK_DIV)) dut (
        .msoc_clk(clk), .rst_int(rst_int),
        .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read),
        .req_phy(req_phy), .req_reg(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .phy_mdc(phy_mdc), .phy_mdio_o(phy_mdio_o),
        .phy_mdio_oe(phy_mdio_oe), .phy_mdio_i(phy_mdio_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        logic [63:0] frame;
        logic [63:0] oe;
        logic        rd;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0, fails = 0;
    int          cnt = 0, acc = 0, resp_seen = 0, capn = 0;
    logic [63:0] cap_d = '0, cap_e = '0;
    logic        mdc_prev = 1'b0;
    int          phy_mode = 0;
    logic [15:0] phy_data = 16'h0;

    always @(posedge clk) cnt <= cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic phy_bit(input int k);
        if (phy_mode == 0) return 1'b1;
        if (k == PRE + 15) return 1'b0;
        if (k >= PRE + 16 && k < PRE + 32) return phy_data[PRE + 31 - k];
        return 1'b1;
    endfunction

    // Monitor: acceptance tracking, frame capture, PHY drive, response scoreboard
    always @(negedge clk) begin
        exp_t e;
        logic [63:0] m;
        if (!rst_int && req_valid && req_ready) begin
            acc   = cnt + 1;
            capn  = 0;
            cap_d = '0;
            cap_e = '0;
        end
        if (phy_mdc === 1'b1 && mdc_prev === 1'b0) begin
            cap_d = {cap_d[62:0], phy_mdio_o};
            cap_e = {cap_e[62:0], phy_mdio_oe};
            capn++;
        end
        mdc_prev = phy_mdc;
        if (phy_mdc !== 1'b1) phy_mdio_i = phy_bit(capn);
        if (rsp_valid === 1'b1) begin
            resp_seen++;
            if (sb.size() == 0) begin
                check("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                m = e.rd ? MASK_RD : MASK_N;
                check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                check("rsp_err", 64'(rsp_err), 64'(e.err));
                check("rsp_cycle", 64'(cnt - acc + 1), 64'(LAT));
                check("mdc_bits", 64'(capn), 64'(N));
                check("oe_pattern", cap_e & MASK_N, e.oe);
                check("frame_bits", cap_d & m, e.frame & m);
            end
        end
    end

    task automatic send(input logic rd, input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] wd);
        bit ok = 1'b0;
        req_read  = rd;
        req_phy   = phy;
        req_reg   = rg;
        req_wdata = wd;
        req_valid = 1'b1;
        for (int i = 0; i < 3 * LAT && !ok; i++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        req_valid = 1'b0;
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_rsp(input int target);
        for (int i = 0; i < 3 * LAT && resp_seen < target; i++) @(negedge clk);
        if (resp_seen < target) check("rsp_timeout", 64'(resp_seen), 64'(target));
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [15:0] rdata, input logic err, input logic rd, input logic [31:0] frm);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.rd    = rd;
        e.frame = {32'hFFFF_FFFF, frm};
        e.oe    = rd ? MASK_RD : MASK_N;
        return e;
    endfunction

    initial begin
        int a0, n0;
        rst_int = 1'b1; req_valid = 1'b0; req_read = 1'b0;
        req_phy = '0; req_reg = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_err", 64'(rsp_err), 64'd0);
        check("rst_mdc", 64'(phy_mdc), 64'd0);
        check("rst_mdio_o", 64'(phy_mdio_o), 64'd1);
        check("rst_oe", 64'(phy_mdio_oe), 64'd0);
        rst_int = 1'b0;
        @(posedge clk);
        #1;

        // write phy 1 reg 0 data 1140
        sb.push_back(mk(16'h0000, 1'b0, 1'b0, {4'b0101, 5'd1, 5'd0, 2'b10, 16'h1140}));
        send(1'b0, 5'd1, 5'd0, 16'h1140);
        wait_rsp(1);

        // read with responding PHY
        phy_mode = 1; phy_data = 16'h796D;
        sb.push_back(mk(16'h796D, 1'b0, 1'b1, {4'b0110, 5'd1, 5'd1, 18'd0}));
        send(1'b1, 5'd1, 5'd1, 16'h0);
        wait_rsp(2);

        // read with MDIO pulled high
        phy_mode = 0;
        sb.push_back(mk(16'hFFFF, 1'b1, 1'b1, {4'b0110, 5'd3, 5'd2, 18'd0}));
        send(1'b1, 5'd3, 5'd2, 16'h0);
        wait_rsp(3);

        // request arriving while busy is held until ready returns
        sb.push_back(mk(16'hFFFF, 1'b0, 1'b0, {4'b0101, 5'h1F, 5'h10, 2'b10, 16'hA5C3}));
        send(1'b0, 5'h1F, 5'h10, 16'hA5C3);
        a0 = acc;
        while (cnt < a0 + 9) begin
            @(posedge clk);
            #1;
        end
        check("busy_ready_low", 64'(req_ready), 64'd0);
        check("busy_flag", 64'(busy), 64'd1);
        sb.push_back(mk(16'hFFFF, 1'b0, 1'b0, {4'b0101, 5'd1, 5'd0, 2'b10, 16'h1140}));
        send(1'b0, 5'd1, 5'd0, 16'h1140);
        check("held_accept_cycle", 64'(acc - a0), 64'(LAT + 1));
        wait_rsp(5);

        // reset in the middle of a write abandons it
        send(1'b0, 5'd2, 5'd3, 16'h1234);
        a0 = acc;
        while (cnt < a0 + 199) begin
            @(posedge clk);
            #1;
        end
        rst_int = 1'b1;
        @(posedge clk);
        #1;
        check("abort_mdc", 64'(phy_mdc), 64'd0);
        check("abort_oe", 64'(phy_mdio_oe), 64'd0);
        check("abort_mdio_o", 64'(phy_mdio_o), 64'd1);
        check("abort_ready", 64'(req_ready), 64'd1);
        check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        check("abort_rdata", 64'(rsp_rdata), 64'd0);
        rst_int = 1'b0;
        n0 = resp_seen;
        repeat (LAT + 20) @(posedge clk);
        #1;
        check("no_rsp_after_abort", 64'(resp_seen - n0), 64'd0);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/eth_mdio_master.md
# eth_mdio_master

Hardware MDIO (IEEE 802.3 clause 22) management master for the RGMII PHY. It replaces software bit-banging of `phy_mdc`, `phy_mdio_o` and `phy_mdio_oe` in the Ethernet framing register block. The block accepts one read or write request at a time from the register decode logic in the `msoc_clk` domain. It serialises the request into an MDIO frame, samples read data, and returns a one-cycle response.

## Interface

Parameters:
- `CLK_DIV`, default 20: `msoc_clk` cycles per MDC half-period. Legal range 2..255.

Ports:
- `msoc_clk`  in  1  block clock; the only clock.
- `rst_int`  in  1  reset; synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block idle and able to accept a request.
- `req_read`  in  1  1 = read (OP 10), 0 = write (OP 01).
- `req_phy`  in  5  PHYAD.
- `req_reg`  in  5  REGAD.
- `req_wdata`  in  16  write data; ignored on reads.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  16  read data; held until the next read completes.
- `rsp_err`  out  1  read turnaround error; valid with `rsp_valid`, then held.
- `busy`  out  1  transaction in progress (equals `~req_ready`).
- `phy_mdc`  out  1  MDC.
- `phy_mdio_o`  out  1  MDIO output data.
- `phy_mdio_oe`  out  1  MDIO output enable.
- `phy_mdio_i`  in  1  MDIO input; already synchronised upstream.

## Operation

- States: IDLE, PRE, HDR, TA, DATA, END.
- IDLE:
  - `req_ready`=1; `phy_mdc`=0, `phy_mdio_oe`=0, `phy_mdio_o`=1.
  - On `req_valid&req_ready`, latch all request fields and go to PRE.
- PRE: 32 bits of 1, `oe`=1.
- HDR: 14 bits, MSB first: ST `01`, OP, PHYAD[4:0], REGAD[4:0].
- TA:
  - Write: drive `10`, `oe`=1.
  - Read: `oe`=0 for both bits. Sample the second TA bit; if it is 1, set the error flag (no PHY responding).
- DATA:
  - Write: drive `req_wdata[15:0]` MSB first, `oe`=1.
  - Read: `oe`=0; shift 16 sampled bits MSB first into a shift register.
- END:
  - Single cycle: `rsp_valid`=1 and `rsp_err` updated (always 0 for writes).
  - For reads only, `rsp_rdata` is loaded from the shift register.
  - Then go to IDLE.
- Bit counter is 6 bits and is reloaded on each state entry.
- Divider counter is 8 bits and counts 0..CLK_DIV-1.
- A read with no PHY attached returns `rsp_rdata`=16'hFFFF (pull-up) and `rsp_err`=1.
- `req_valid` while busy is ignored; no queueing. The requester holds the request until it is accepted.
- Reset (`rst_int`=1 in any state) takes effect at the next edge:
  - Return to IDLE; MDIO lines go to their IDLE values.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - Any frame in progress is abandoned without a response.

## Timing

- Reset values: `req_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `phy_mdc`=0, `phy_mdio_o`=1, `phy_mdio_oe`=0.
- Per-bit timing:
  - Each bit is CLK_DIV cycles with MDC low, then CLK_DIV cycles with MDC high.
  - `phy_mdio_o` and `phy_mdio_oe` change only on the first cycle of the low phase, giving CLK_DIV cycles of setup before the rising edge.
- `phy_mdio_i` is sampled on the cycle `phy_mdc` goes 0→1, i.e. the first high-phase cycle of each read bit.
- Acceptance timing:
  - Request accepted at edge 0.
  - First MDC low phase starts at cycle 1.
  - `req_ready` is low from cycle 1.
- Frame length N = 64 bits (32 without preamble).
- Completion:
  - `rsp_valid` is asserted at cycle 1 + 2·CLK_DIV·N.
  - `req_ready` returns the cycle after.
  - Next acceptance no earlier than cycle 2 + 2·CLK_DIV·N.
- After the last bit, MDC is held low and `oe`=0 in END/IDLE.

## Configuration

- `ETH_MDIO_PREAMBLE_SUPPRESS_EN`:
  - Defined: the PRE state is skipped; IDLE goes directly to HDR, and N=32.
  - Undefined: a full 32-bit preamble precedes every frame, and N=64.
- No other behaviour differs.

## Test plan

- Write, CLK_DIV=4: phy=1, reg=0, wdata=16'h1140. Serial stream captured on MDC rising edges is 32×1, `0101 00001 00000 10 0001000101000000`. `oe`=1 throughout; `rsp_valid` at cycle 513 with `rsp_err`=0.
- Read, CLK_DIV=4: PHY model drives 0 on the second TA bit, then 16'h796D. Response has `rsp_rdata`=16'h796D, `rsp_err`=0. `oe`=0 for the final 18 bits.
- Read with `phy_mdio_i` tied high: `rsp_rdata`=16'hFFFF, `rsp_err`=1.
- Second `req_valid` asserted at cycle 10 of a transaction: ignored, with no MDC activity change. Held until `req_ready` returns; accepted on the cycle after `rsp_valid`.
- `rst_int` asserted at cycle 200 of a write: next cycle shows `phy_mdc`=0, `oe`=0, `req_ready`=1, and no `rsp_valid` pulse.
- With `ETH_MDIO_PREAMBLE_SUPPRESS_EN` and CLK_DIV=2: the frame starts with `01`, and `rsp_valid` arrives at cycle 129.
